// File: rtl/cpht_pkg.sv
// Shared definitions for the choice-predictor update path: default widths,
// pointer sizing and the layout of the payload word kept per queue entry.
package cpht_pkg;

  localparam int CH_WIDTH      = 14;
  localparam int DEPTH_DEFAULT = 8;

  // Payload word layout: {choice_pdc, hashed_pc}, hashed_pc in the low bits.
  localparam int PL_PC_LSB = 0;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int payload_width(input int ch_width);
    return ch_width + 1;
  endfunction

  function automatic int pl_choice_bit(input int ch_width);
    return PL_PC_LSB + ch_width;
  endfunction

endpackage

// File: rtl/sp_dram.sv
// Distributed RAM: one synchronous write port, one asynchronous read port.
module sp_dram #(
  parameter int DW    = 15,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: storage arrays get no reset; validity is tracked in flops elsewhere,
  // and a reset here would stop the array mapping onto LUT RAM.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/cpht_update_queue.sv
// In-order tracker of choice predictions; retires resolved entries from the
// head as one choice-table update per cycle.
module cpht_update_queue
  import cpht_pkg::*;
#(
  parameter  int ch_width = CH_WIDTH,
  parameter  int DEPTH    = DEPTH_DEFAULT,
  localparam int PTR_W    = ptr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pdc_valid,
  input  logic [ch_width-1:0] pdc_hashed_pc,
  input  logic                pdc_choice,
  output logic                pdc_ready,
  output logic [PTR_W-1:0]    pdc_tag,
  input  logic                res_valid,
  input  logic [PTR_W-1:0]    res_tag,
  input  logic                res_choice_real,
  input  logic                flush_valid,
  input  logic [PTR_W-1:0]    flush_tag,
  input  logic                flush_all,
  output logic                upd_en,
  output logic [ch_width-1:0] upd_hashed_pc,
  output logic                upd_choice_pdc_ex,
  output logic                upd_choice_real,
  output logic [PTR_W:0]      count
);

  localparam int PL_W = payload_width(ch_width);
  localparam int PL_CH = pl_choice_bit(ch_width);

  logic [PTR_W:0]     r_head, r_tail;
  logic [DEPTH-1:0]   r_valid, r_done, r_real;

  logic [PTR_W-1:0]   w_head_idx, w_tail_idx;
  logic [PTR_W:0]     w_head_next;
  logic               w_drain, w_push, w_resolve, w_flush_live;
  logic [PTR_W-1:0]   w_flush_off, w_res_off;
  logic               w_res_survives;
  logic [DEPTH-1:0]   w_keep, w_valid_next;
  logic [PL_W-1:0]    w_rd_data;

  assign w_head_idx  = r_head[PTR_W-1:0];
  assign w_tail_idx  = r_tail[PTR_W-1:0];
  assign count       = r_tail - r_head;
  assign pdc_ready   = (count != (PTR_W+1)'(DEPTH));
  assign pdc_tag     = w_tail_idx;

  assign w_drain     = r_valid[w_head_idx] & r_done[w_head_idx];
  assign w_head_next = r_head + {{PTR_W{1'b0}}, w_drain};
  assign w_push      = pdc_valid & pdc_ready & ~flush_all & ~flush_valid;

  // Distances from head order entries by age regardless of wrap.
  assign w_flush_live   = flush_valid & ~flush_all & r_valid[flush_tag];
  assign w_flush_off    = flush_tag - w_head_idx;
  assign w_res_off      = res_tag - w_head_idx;
  assign w_res_survives = ~flush_all & (~w_flush_live | (w_res_off <= w_flush_off));
  assign w_resolve      = res_valid & r_valid[res_tag] & ~r_done[res_tag] & w_res_survives;

  // NOTE: every always_comb output is assigned a default before any branch,
  // so no path leaves it holding its old value (which would infer a latch).
  always_comb begin
    w_keep = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_all) begin
        w_keep[i] = 1'b0;
      end else if (w_flush_live && ((PTR_W'(i) - w_head_idx) > w_flush_off)) begin
        w_keep[i] = 1'b0;
      end
    end
    w_valid_next = r_valid & w_keep;
    if (w_drain) w_valid_next[w_head_idx] = 1'b0;
    if (w_push)  w_valid_next[w_tail_idx] = 1'b1;
  end

  sp_dram #(
    .DW    (PL_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_payload (
    .clk   (clk),
    .we    (w_push),
    .waddr (w_tail_idx),
    .wdata ({pdc_choice, pdc_hashed_pc}),
    .raddr (w_head_idx),
    .rdata (w_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_valid           <= '0;
      r_done            <= '0;
      r_real            <= '0;
      upd_en            <= 1'b0;
      upd_hashed_pc     <= '0;
      upd_choice_pdc_ex <= 1'b0;
      upd_choice_real   <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_head  <= w_head_next;

      // A full flush keeps the tail level with the post-drain head.
      if (flush_all)         r_tail <= w_head_next;
      else if (w_flush_live) r_tail <= r_head + {1'b0, w_flush_off} + (PTR_W+1)'(1);
      else if (w_push)       r_tail <= r_tail + (PTR_W+1)'(1);

      if (w_push) r_done[w_tail_idx] <= 1'b0;
      if (w_resolve) begin
        r_done[res_tag] <= 1'b1;
        r_real[res_tag] <= res_choice_real;
      end

      upd_en <= w_drain;
      if (w_drain) begin
        upd_hashed_pc     <= w_rd_data[PL_PC_LSB +: ch_width];
        upd_choice_pdc_ex <= w_rd_data[PL_CH];
        upd_choice_real   <= r_real[w_head_idx];
      end
    end
  end

endmodule

// File: doc/cpht_update_queue.md
# cpht_update_queue

Tracks every choice prediction made by the choice-predictor table from issue until resolution. It then drives that table's update port in program order, one write per cycle. It sits between the fetch-side query of the choice table and the execute/commit-side branch resolution. It supplies the hashed index, the predicted choice and the real choice for each 2-bit counter update.

## Interface
- ch_width, 14, width of hashed PC/GH index (matches choice table)
- DEPTH, 8, queue entries; power of two, ≥2
- PTR_W, log2(DEPTH), tag width (derived, not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- pdc_valid  in  1  a choice prediction was made this cycle
- pdc_hashed_pc  in  ch_width  index used for the query
- pdc_choice  in  1  predicted choice bit returned by the table
- pdc_ready  out  1  queue can accept a push (count < DEPTH)
- pdc_tag  out  PTR_W  slot that the current push will occupy (= tail index)
- res_valid  in  1  resolution for one entry
- res_tag  in  PTR_W  entry being resolved
- res_choice_real  in  1  which component was actually correct
- flush_valid  in  1  discard entries younger than flush_tag
- flush_tag  in  PTR_W  youngest surviving entry
- flush_all  in  1  discard every entry
- upd_en  out  1  update strobe to table (update_en)
- upd_hashed_pc  out  ch_width  → hashed_pc_update
- upd_choice_pdc_ex  out  1  → choice_pdc_ex
- upd_choice_real  out  1  → choice_real
- count  out  PTR_W+1  live entries

## Operation
- Circular buffer with head/tail pointers of PTR_W+1 bits; the extra bit is the wrap bit. full = same index, different wrap bit. empty = pointers equal.
- Per entry: valid, done, choice_pdc, choice_real, hashed_pc.
- Push: pdc_valid & pdc_ready → write entry at tail, valid=1, done=0, tail+1.
- Resolve: res_valid with a live, not-done res_tag → done=1 and store choice_real. Resolve of a dead or already-done tag is ignored, with no state change.
- Drain: if head entry is valid & done → register its fields onto upd_* with upd_en=1, clear valid, head+1. At most one drain per cycle, strictly in order; a resolved younger entry waits behind an unresolved head.
- flush_all: clears all valid bits and sets tail=head. An in-flight drain of the head that cycle still completes (upd_en issued).
- flush_valid, flush_tag live: tail = flush_tag+1 with the correct wrap bit, and younger valid bits are cleared. If flush_tag is dead, the flush is ignored.
- Priority when events coincide: flush_all > flush_valid > push.
  - A push in a flush cycle is dropped.
  - A resolve in a flush cycle applies only if its tag survives.
  - A drain and a resolve on the same cycle are both legal.
- pdc_ready does not anticipate a same-cycle drain. When full, a push is refused even if the head drains.
- Push and drain in the same cycle: count is unchanged.

## Timing
- Reset values: head=tail=0, all valid/done=0, count=0, pdc_ready=1, pdc_tag=0, upd_en=0, upd_hashed_pc=0, upd_choice_pdc_ex=0, upd_choice_real=0.
- Reset mid-operation discards all entries; no update is issued for them.
- pdc_ready, pdc_tag and count are combinational from registered state.
- Resolve presented in cycle k to a head entry → upd_en high in cycle k+2: done is set at edge k, upd_* is registered at edge k+1.
- upd_en is a single-cycle pulse per entry. upd_* hold their last values when upd_en=0.
- A push at cycle k is resolvable from cycle k+1. A resolve in the same cycle as its push is ignored.
- Sustained throughput is one push and one update per cycle.

## Structure
- Shared package cpht_pkg:
  - CH_WIDTH default
  - ptr-width function (clog2)
  - entry field widths/offsets shared with the choice table and branch unit
- The hashed_pc/choice_pdc payload is stored in one sp_dram instance. It has an asynchronous read at head and a write at tail, with data width ch_width+1.
- valid/done/choice_real are flop vectors, because resolve needs random-access writes.

## Test plan
- Reset, then push hashed_pc 0x0123/choice 1 and resolve tag 0 with real 0 → upd_en pulses once with 0x0123, pdc_ex=1, real=0, two cycles after the resolve; count returns to 0.
- Push 8 entries → pdc_ready=0 and count=8. A 9th push is refused. Resolve tag 0 → drain → pdc_ready=1, and the next push gets pdc_tag=0 (wrap-around).
- Push tags 0–3 and resolve 3, 2, 1 → no upd_en. Resolve 0 → four consecutive upd_en pulses in order 0, 1, 2, 3.
- Push tags 0–5, then flush_valid with flush_tag=2 plus a simultaneous push → count=3 and the push is dropped. A resolve of tag 4 is ignored, and the next pdc_tag=3.
- Head resolved, with flush_all in the cycle the drain registers → that update still issues and count=0. Later resolves of the old tags produce no upd_en.
- Assert rstn low while 5 entries are live and 2 are resolved → all outputs return to reset values immediately, and no upd_en follows the release of reset.
